alu_seq: RTL and testbench

- Next-generation execute-stage ALU. Width is parametrised and a valid/ready handshake is added on both sides.
- Keeps all existing single-cycle FN_* arithmetic, logic and compare functions.
- Adds single-cycle shifts, an iterative shift-add multiplier (low and high product) and an iterative restoring divider (quotient and remainder).
- One operation in flight; the result is held until consumed. The pipeline stalls on in_ready low.

---
 rtl/alu_seq.sv | 183 ++++++++++++++++++
 tb/tb_alu_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - execute-stage ALU with valid/ready handshake, iterative multiply and divide
module alu_seq #(
    parameter int BIT_WIDTH = 32,
    parameter int TAG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           alu_fn,
    input  logic [BIT_WIDTH-1:0] in1,
    input  logic [BIT_WIDTH-1:0] in2,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 div_zero,
    output logic                 busy
);
    localparam int SHW = $clog2(BIT_WIDTH);
    localparam logic [SHW-1:0] LAST_CNT = SHW'(BIT_WIDTH - 2);

    localparam logic [4:0] FN_ADD  = 5'h00, FN_SUB  = 5'h01, FN_AND  = 5'h02, FN_OR   = 5'h03;
    localparam logic [4:0] FN_XOR  = 5'h04, FN_NOR  = 5'h05, FN_NAND = 5'h06, FN_XNOR = 5'h07;
    localparam logic [4:0] FN_EQ   = 5'h08, FN_NE   = 5'h09, FN_LT   = 5'h0A, FN_LE   = 5'h0B;
    localparam logic [4:0] FN_GT   = 5'h0C, FN_GE   = 5'h0D, FN_T    = 5'h0E, FN_F    = 5'h0F;
    localparam logic [4:0] FN_SLL  = 5'h10, FN_SRL  = 5'h11, FN_SRA  = 5'h12, FN_MUL  = 5'h13;
    localparam logic [4:0] FN_MULH = 5'h14, FN_DIV  = 5'h15, FN_REM  = 5'h16;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [SHW-1:0]        cnt_q, cnt_d;
    logic [BIT_WIDTH-1:0]  acc_q, acc_d, lo_q, lo_d, opnd_q, opnd_d;
    logic                  hi_sel_q, hi_sel_d;
    logic [BIT_WIDTH-1:0]  out_q, out_d;
    logic [TAG_WIDTH-1:0]  out_tag_q, out_tag_d;
    logic                  div_zero_q, div_zero_d;

    logic                  accept, is_mul_fn, is_div_fn;
    logic [SHW-1:0]        shamt;
    logic [BIT_WIDTH-1:0]  alu_res;
    logic [BIT_WIDTH-1:0]  s_acc, s_lo, s_opnd;
    logic [BIT_WIDTH:0]    mul_sum, div_shift, div_diff;
    logic [BIT_WIDTH-1:0]  mul_acc, mul_lo, div_acc, div_lo;
    logic                  div_ge;

    assign in_ready  = !reset && !flush && (state_q == S_IDLE || (state_q == S_DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign is_mul_fn = (alu_fn == FN_MUL) || (alu_fn == FN_MULH);
    assign is_div_fn = (alu_fn == FN_DIV) || (alu_fn == FN_REM);
    assign shamt     = in2[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (alu_fn)
            FN_ADD:  alu_res = in1 + in2;
            FN_SUB:  alu_res = in1 - in2;
            FN_AND:  alu_res = in1 & in2;
            FN_OR:   alu_res = in1 | in2;
            FN_XOR:  alu_res = in1 ^ in2;
            FN_NOR:  alu_res = ~(in1 | in2);
            FN_NAND: alu_res = ~(in1 & in2);
            FN_XNOR: alu_res = ~(in1 ^ in2);
            FN_EQ:   alu_res = BIT_WIDTH'(in1 == in2);
            FN_NE:   alu_res = BIT_WIDTH'(in1 != in2);
            FN_LT:   alu_res = BIT_WIDTH'(in1 < in2);
            FN_LE:   alu_res = BIT_WIDTH'(in1 <= in2);
            FN_GT:   alu_res = BIT_WIDTH'(in1 > in2);
            FN_GE:   alu_res = BIT_WIDTH'(in1 >= in2);
            FN_T:    alu_res = BIT_WIDTH'(1);
            FN_F:    alu_res = '0;
            FN_SLL:  alu_res = in1 << shamt;
            FN_SRL:  alu_res = in1 >> shamt;
            FN_SRA:  alu_res = $signed(in1) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // The accept edge performs the first iteration straight from the operand inputs,
    // so an iterative op finishes BIT_WIDTH edges after it is accepted.
    always_comb begin
        s_acc  = accept ? '0 : acc_q;
        s_lo   = accept ? (is_div_fn ? in1 : in2) : lo_q;
        s_opnd = accept ? (is_div_fn ? in2 : in1) : opnd_q;

        mul_sum = {1'b0, s_acc} + (s_lo[0] ? {1'b0, s_opnd} : '0);
        mul_acc = mul_sum[BIT_WIDTH:1];
        mul_lo  = {mul_sum[0], s_lo[BIT_WIDTH-1:1]};

        // Partial remainder stays below the divisor, so the borrow bit alone decides the step.
        div_shift = {s_acc, s_lo[BIT_WIDTH-1]};
        div_diff  = div_shift - {1'b0, s_opnd};
        div_ge    = !div_diff[BIT_WIDTH];
        div_acc   = div_ge ? div_diff[BIT_WIDTH-1:0] : div_shift[BIT_WIDTH-1:0];
        div_lo    = {s_lo[BIT_WIDTH-2:0], div_ge};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        lo_d       = lo_q;
        opnd_d     = opnd_q;
        hi_sel_d   = hi_sel_q;
        out_d      = out_q;
        out_tag_d  = out_tag_q;
        div_zero_d = div_zero_q;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (accept) begin
            out_tag_d  = in_tag;
            div_zero_d = 1'b0;
            cnt_d      = '0;
            hi_sel_d   = (alu_fn == FN_MULH) || (alu_fn == FN_REM);
            if (is_mul_fn) begin
                acc_d   = mul_acc;
                lo_d    = mul_lo;
                opnd_d  = in1;
                state_d = S_MUL;
            end else if (is_div_fn && in2 == '0) begin
                out_d      = (alu_fn == FN_DIV) ? '1 : in1;
                div_zero_d = 1'b1;
                state_d    = S_DONE;
            end else if (is_div_fn) begin
                acc_d   = div_acc;
                lo_d    = div_lo;
                opnd_d  = in2;
                state_d = S_DIV;
            end else begin
                out_d   = alu_res;
                state_d = S_DONE;
            end
        end else begin
            case (state_q)
                S_MUL, S_DIV: begin
                    acc_d = (state_q == S_MUL) ? mul_acc : div_acc;
                    lo_d  = (state_q == S_MUL) ? mul_lo : div_lo;
                    cnt_d = cnt_q + SHW'(1);
                    if (cnt_q == LAST_CNT) begin
                        out_d   = hi_sel_q ? acc_d : lo_d;
                        state_d = S_DONE;
                    end
                end
                S_DONE: if (out_ready) state_d = S_IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            lo_q       <= '0;
            opnd_q     <= '0;
            hi_sel_q   <= 1'b0;
            out_q      <= '0;
            out_tag_q  <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            lo_q       <= lo_d;
            opnd_q     <= opnd_d;
            hi_sel_q   <= hi_sel_d;
            out_q      <= out_d;
            out_tag_q  <= out_tag_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
    assign out       = out_q;
    assign out_tag   = out_tag_q;
    assign div_zero  = div_zero_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed and randomized checks of alu_seq against an arithmetic model
module tb_alu_seq;
    localparam logic [4:0] FN_ADD = 5'h00, FN_SUB = 5'h01, FN_LT = 5'h0A, FN_SRA = 5'h12;
    localparam logic [4:0] FN_MUL = 5'h13, FN_MULH = 5'h14, FN_DIV = 5'h15, FN_REM = 5'h16;

    logic clk = 1'b0;
    logic reset, flush;
    logic iv, ir, ov, ordy, dz, bsy;
    logic [4:0] fn, tg, otg;
    logic [31:0] a, b, o;
    logic iv8, ir8, ov8, dz8, bsy8;
    logic [4:0] fn8, tg8, otg8;
    logic [7:0] a8, b8, o8;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_out;

    always #5 clk = ~clk;

    alu_seq #(.BIT_WIDTH(32), .TAG_WIDTH(5)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(iv), .in_ready(ir), .alu_fn(fn),
        .in1(a), .in2(b), .in_tag(tg), .out_valid(ov), .out_ready(ordy), .out(o),
        .out_tag(otg), .div_zero(dz), .busy(bsy)
    );

    alu_seq #(.BIT_WIDTH(8), .TAG_WIDTH(5)) dut8 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(iv8), .in_ready(ir8), .alu_fn(fn8),
        .in1(a8), .in2(b8), .in_tag(tg8), .out_valid(ov8), .out_ready(ordy), .out(o8),
        .out_tag(otg8), .div_zero(dz8), .busy(bsy8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Result of fn on w-bit unsigned operands, plus the divide-by-zero flag and expected latency.
    function automatic void model(input logic [4:0] f, input logic [63:0] xi, input logic [63:0] yi,
                                  input int w, output logic [63:0] r, output logic z, output int lat);
        logic [63:0] m, x, y;
        int sh;
        m = (64'd1 << w) - 64'd1;
        x = xi & m;
        y = yi & m;
        sh = int'(y % 64'(w));
        z = 1'b0;
        lat = 1;
        r = '0;
        case (f)
            5'h00: r = x + y;
            5'h01: r = x - y;
            5'h02: r = x & y;
            5'h03: r = x | y;
            5'h04: r = x ^ y;
            5'h05: r = ~(x | y);
            5'h06: r = ~(x & y);
            5'h07: r = ~(x ^ y);
            5'h08: r = 64'(x == y);
            5'h09: r = 64'(x != y);
            5'h0A: r = 64'(x < y);
            5'h0B: r = 64'(x <= y);
            5'h0C: r = 64'(x > y);
            5'h0D: r = 64'(x >= y);
            5'h0E: r = 64'd1;
            5'h0F: r = 64'd0;
            5'h10: r = x << sh;
            5'h11: r = x >> sh;
            5'h12: begin
                r = x >> sh;
                if (x[w-1]) r = r | (m & ~(m >> sh));
            end
            5'h13: begin r = x * y; lat = w; end
            5'h14: begin r = (x * y) >> w; lat = w; end
            5'h15: if (y == 0) begin r = m; z = 1'b1; end else begin r = x / y; lat = w; end
            5'h16: if (y == 0) begin r = x; z = 1'b1; end else begin r = x % y; lat = w; end
            default: r = 64'd0;
        endcase
        r = r & m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iv = 1'b0;
        iv8 = 1'b0;
        tick();
    endtask

    task automatic do_op(input bit n8, input logic [4:0] f, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] t, input string name);
        logic [63:0] er;
        logic ez;
        int el, lat, busy_n, rdy_n, w;
        w = n8 ? 8 : 32;
        model(f, {32'b0, x}, {32'b0, y}, w, er, ez, el);
        if (n8) begin fn8 = f; a8 = x[7:0]; b8 = y[7:0]; tg8 = t; iv8 = 1'b1; end
        else begin fn = f; a = x; b = y; tg = t; iv = 1'b1; end
        check({name, " in_ready"}, 64'(n8 ? ir8 : ir), 64'd1);
        tick();
        iv = 1'b0; iv8 = 1'b0;
        a = $urandom; b = $urandom; fn = 5'($urandom); tg = 5'($urandom);
        a8 = 8'($urandom); b8 = 8'($urandom); fn8 = 5'($urandom); tg8 = 5'($urandom);
        lat = 1; busy_n = 0; rdy_n = 0;
        while (!(n8 ? ov8 : ov) && lat < 100) begin
            if (n8 ? bsy8 : bsy) busy_n++;
            if (n8 ? ir8 : ir) rdy_n++;
            tick();
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'(el));
        check({name, " busy cycles"}, 64'(busy_n), 64'(el - 1));
        check({name, " in_ready while busy"}, 64'(rdy_n), 64'd0);
        check({name, " out"}, 64'(n8 ? {24'b0, o8} : o), er);
        check({name, " tag"}, 64'(n8 ? otg8 : otg), 64'(t));
        check({name, " div_zero"}, 64'(n8 ? dz8 : dz), 64'(ez));
        last_out = n8 ? {24'b0, o8} : o;
    endtask

    logic [4:0]  bf [4] = '{FN_SUB, FN_LT, FN_SUB, FN_LT};
    logic [31:0] ba [4] = '{32'hFFFF_FFFF, 32'd3, 32'd0, 32'd9};
    logic [31:0] bb [4] = '{32'd1, 32'd5, 32'd1, 32'd2};

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] er;
        logic ez;
        int el, cnt;
        reset = 1'b1; flush = 1'b0; ordy = 1'b1;
        iv = 1'b0; fn = '0; a = '0; b = '0; tg = '0;
        iv8 = 1'b0; fn8 = '0; a8 = '0; b8 = '0; tg8 = '0;
        #2;
        check("reset out_valid", 64'(ov), 64'd0);
        check("reset busy", 64'(bsy), 64'd0);
        check("reset out", 64'(o), 64'd0);
        check("reset out_tag", 64'(otg), 64'd0);
        check("reset div_zero", 64'(dz), 64'd0);
        #10 reset = 1'b0;
        tick();
        check("post reset in_ready", 64'(ir), 64'd1);
        check("post reset out_valid", 64'(ov), 64'd0);

        do_op(1'b0, FN_ADD, 32'hFFFF_FFFF, 32'd1, 5'd3, "add wrap");
        check("add in_ready stays", 64'(ir), 64'd1);

        for (int i = 0; i < 4; i++) begin
            model(bf[i], {32'b0, ba[i]}, {32'b0, bb[i]}, 32, er, ez, el);
            fn = bf[i]; a = ba[i]; b = bb[i]; tg = 5'(i + 10); iv = 1'b1;
            tick();
            check("b2b out_valid", 64'(ov), 64'd1);
            check("b2b out", 64'(o), er);
            check("b2b tag", 64'(otg), 64'(i + 10));
        end
        idle();

        do_op(1'b0, FN_MUL, 32'h8000_0001, 32'h0000_0003, 5'd1, "mul");
        check("mul const", 64'(last_out), 64'h8000_0003);
        do_op(1'b0, FN_MULH, 32'h8000_0001, 32'h0000_0003, 5'd2, "mulh");
        check("mulh const", 64'(last_out), 64'd1);
        do_op(1'b0, FN_DIV, 32'd100, 32'd7, 5'd4, "div");
        check("div const", 64'(last_out), 64'd14);
        do_op(1'b0, FN_REM, 32'd100, 32'd7, 5'd5, "rem");
        check("rem const", 64'(last_out), 64'd2);
        do_op(1'b0, FN_DIV, 32'd55, 32'd0, 5'd6, "div0");
        check("div0 const", 64'(last_out), 64'hFFFF_FFFF);
        do_op(1'b0, FN_REM, 32'd55, 32'd0, 5'd7, "rem0");
        check("rem0 const", 64'(last_out), 64'd55);

        idle();
        ordy = 1'b0;
        fn = FN_ADD; a = 32'h1234; b = 32'h1111; tg = 5'd9; iv = 1'b1;
        tick();
        iv = 1'b0;
        check("hold first valid", 64'(ov), 64'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("hold out_valid", 64'(ov), 64'd1);
            check("hold out", 64'(o), 64'h2345);
            check("hold tag", 64'(otg), 64'd9);
            check("hold in_ready", 64'(ir), 64'd0);
        end
        fn = FN_SUB; a = 32'd10; b = 32'd3; tg = 5'd4; iv = 1'b1; ordy = 1'b1;
        #1;
        check("release in_ready", 64'(ir), 64'd1);
        tick();
        iv = 1'b0;
        check("release out_valid", 64'(ov), 64'd1);
        check("release out", 64'(o), 64'd7);
        check("release tag", 64'(otg), 64'd4);

        idle();
        fn = FN_DIV; a = 32'd1000; b = 32'd3; tg = 5'd6; iv = 1'b1;
        tick();
        iv = 1'b0;
        repeat (9) tick();
        check("pre reset busy", 64'(bsy), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("async reset out_valid", 64'(ov), 64'd0);
        check("async reset busy", 64'(bsy), 64'd0);
        check("async reset out", 64'(o), 64'd0);
        check("async reset tag", 64'(otg), 64'd0);
        check("async reset div_zero", 64'(dz), 64'd0);
        check("async reset in_ready", 64'(ir), 64'd0);
        #2 reset = 1'b0;
        tick();
        check("after reset in_ready", 64'(ir), 64'd1);

        fn = FN_MUL; a = 32'd5; b = 32'd7; tg = 5'd8; iv = 1'b1;
        tick();
        iv = 1'b0;
        repeat (4) tick();
        flush = 1'b1; fn = FN_ADD; a = 32'd1; b = 32'd1; iv = 1'b1;
        #1;
        check("flush in_ready", 64'(ir), 64'd0);
        check("flush busy before", 64'(bsy), 64'd1);
        tick();
        flush = 1'b0; iv = 1'b0;
        check("flush out_valid", 64'(ov), 64'd0);
        check("flush busy", 64'(bsy), 64'd0);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (ov) cnt++;
            tick();
        end
        check("flush no result", 64'(cnt), 64'd0);

        do_op(1'b0, FN_SRA, 32'h8000_0000, 32'd4, 5'd11, "sra");
        check("sra const", 64'(last_out), 64'hF800_0000);

        do_op(1'b1, FN_MUL, 32'd15, 32'd17, 5'd12, "mul8");
        check("mul8 const", 64'(last_out), 64'hFF);
        do_op(1'b1, FN_MULH, 32'd15, 32'd17, 5'd13, "mulh8");
        check("mulh8 const", 64'(last_out), 64'd0);

        for (int i = 0; i < 80; i++) begin
            logic [31:0] ry;
            ry = ($urandom_range(0, 5) == 0) ? 32'd0 :
                 ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 300));
            do_op((i % 4) == 3, 5'($urandom_range(0, 31)), $urandom, ry, 5'($urandom), "rand");
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
